// File: rtl/gate_seq_ctrl_if.sv
// Gate-matrix stream from the gate source (ROM or host FIFO) into the sequencing controller.
// complexNum words are 16 bits: {re[7:0], im[7:0]}, sign-magnitude, 6 fractional bits.
interface gate_seq_ctrl_if #(
  parameter int N = 2
);
  localparam int DIM = 1 << N;

  logic                          gate_valid;
  logic                          gate_ready;
  logic [DIM-1:0][DIM-1:0][15:0] gate_in;

  modport master (
    output gate_valid,
    output gate_in,
    input  gate_ready
  );

  modport slave (
    input  gate_valid,
    input  gate_in,
    output gate_ready
  );
endinterface

// File: rtl/gate_seq_ctrl.sv
// Sequencing controller for gateStateMult: initialises the 2^N-element state register to |0..0>
// and writes the multiplier result back once per accepted gate matrix.
module gate_seq_ctrl #(
  parameter  int N   = 2,
  parameter  int LAT = 1,
  localparam int DIM = 1 << N
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          abort,
  input  logic [7:0]                    num_gates,
  gate_seq_ctrl_if.slave                gate_bus,
  output logic [DIM-1:0][15:0]          mult_state,
  output logic [DIM-1:0][DIM-1:0][15:0] mult_gate,
  input  logic [DIM-1:0][15:0]          mult_result,
  output logic [DIM-1:0][15:0]          state_out,
  output logic [7:0]                    gates_done,
  output logic                          busy,
  output logic                          done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_LOAD,
    S_APPLY,
    S_WRITE,
    S_DONE
  } fsm_e;

  localparam logic [3:0]  LAT_LOAD = 4'(LAT - 1);
  localparam logic [15:0] ONE      = 16'h4000;

  fsm_e                          fsm_q, fsm_d;
  logic [7:0]                    num_q, num_d;
  logic [7:0]                    cnt_q, cnt_d;
  logic [3:0]                    lat_q, lat_d;
  logic [DIM-1:0][15:0]          vec_q, vec_d;
  logic [DIM-1:0][DIM-1:0][15:0] gate_q, gate_d;
  logic                          busy_q, busy_d;
  logic                          ready_q, ready_d;
  logic                          done_q, done_d;

  always_comb begin
    fsm_d  = fsm_q;
    num_d  = num_q;
    cnt_d  = cnt_q;
    lat_d  = lat_q;
    vec_d  = vec_q;
    gate_d = gate_q;

    // abort freezes every data register, so it also suppresses a same-cycle write-back or latch
    if (abort) begin
      fsm_d = S_IDLE;
    end else begin
      unique case (fsm_q)
        S_IDLE: begin
          if (start) begin
            fsm_d = S_INIT;
            num_d = num_gates;
            cnt_d = '0;
          end
        end
        S_INIT: begin
          vec_d    = '0;
          vec_d[0] = ONE;
          fsm_d    = (num_q == '0) ? S_DONE : S_LOAD;
        end
        S_LOAD: begin
          if (gate_bus.gate_valid && ready_q) begin
            gate_d = gate_bus.gate_in;
            lat_d  = LAT_LOAD;
            fsm_d  = S_APPLY;
          end
        end
        S_APPLY: begin
          if (lat_q == '0) begin
            fsm_d = S_WRITE;
          end else begin
            lat_d = lat_q - 4'd1;
          end
        end
        S_WRITE: begin
          vec_d = mult_result;
          cnt_d = cnt_q + 8'd1;
          fsm_d = (cnt_d == num_q) ? S_DONE : S_LOAD;
        end
        S_DONE: begin
          fsm_d = S_IDLE;
        end
        default: begin
          fsm_d = S_IDLE;
        end
      endcase
    end

    // Status outputs are decoded from the next state so they line up with the registered FSM
    busy_d  = (fsm_d != S_IDLE);
    ready_d = (fsm_d == S_LOAD);
    done_d  = (fsm_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q   <= S_IDLE;
      num_q   <= '0;
      cnt_q   <= '0;
      lat_q   <= '0;
      vec_q   <= '0;
      gate_q  <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      vec_q   <= vec_d;
      gate_q  <= gate_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign gate_bus.gate_ready = ready_q;
  assign mult_state          = vec_q;
  assign state_out           = vec_q;
  assign mult_gate           = gate_q;
  assign gates_done          = cnt_q;
  assign busy                = busy_q;
  assign done                = done_q;

endmodule

// File: tb/tb_gate_seq_ctrl.sv
// Directed bench for gate_seq_ctrl: three instances (LAT=1, 2, 4) with a sign-magnitude
// reference multiplier on the first two and a bench-driven result pattern on the third.
module tb_gate_seq_ctrl;
  localparam int N   = 2;
  localparam int DIM = 1 << N;
  typedef logic [DIM-1:0][15:0]          vec_t;
  typedef logic [DIM-1:0][DIM-1:0][15:0] mat_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       start_a [3];
  logic       abort_a [3];
  logic       gv_a    [3];
  logic       gr_a    [3];
  logic       busy_a  [3];
  logic       done_a  [3];
  logic [7:0] ng_a    [3];
  logic [7:0] gd_a    [3];
  mat_t       gin_a   [3];
  mat_t       mg_a    [3];
  vec_t       ms_a    [3];
  vec_t       so_a    [3];
  vec_t       mr_a    [3];
  vec_t       pat_v;

  mat_t xi;
  vec_t e0, e2;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   done_cyc, ready_seen, stall_ready_ok;
  logic busy_after_abort;
  int   bad;

  gate_seq_ctrl_if #(.N(N)) gbus0 ();
  gate_seq_ctrl_if #(.N(N)) gbus1 ();
  gate_seq_ctrl_if #(.N(N)) gbus2 ();

  assign gbus0.gate_valid = gv_a[0];
  assign gbus0.gate_in    = gin_a[0];
  assign gr_a[0]          = gbus0.gate_ready;
  assign gbus1.gate_valid = gv_a[1];
  assign gbus1.gate_in    = gin_a[1];
  assign gr_a[1]          = gbus1.gate_ready;
  assign gbus2.gate_valid = gv_a[2];
  assign gbus2.gate_in    = gin_a[2];
  assign gr_a[2]          = gbus2.gate_ready;

  gate_seq_ctrl #(.N(N), .LAT(1)) dut0 (
    .clk(clk), .reset(reset), .start(start_a[0]), .abort(abort_a[0]), .num_gates(ng_a[0]),
    .gate_bus(gbus0), .mult_state(ms_a[0]), .mult_gate(mg_a[0]), .mult_result(mr_a[0]),
    .state_out(so_a[0]), .gates_done(gd_a[0]), .busy(busy_a[0]), .done(done_a[0])
  );
  gate_seq_ctrl #(.N(N), .LAT(2)) dut1 (
    .clk(clk), .reset(reset), .start(start_a[1]), .abort(abort_a[1]), .num_gates(ng_a[1]),
    .gate_bus(gbus1), .mult_state(ms_a[1]), .mult_gate(mg_a[1]), .mult_result(mr_a[1]),
    .state_out(so_a[1]), .gates_done(gd_a[1]), .busy(busy_a[1]), .done(done_a[1])
  );
  gate_seq_ctrl #(.N(N), .LAT(4)) dut2 (
    .clk(clk), .reset(reset), .start(start_a[2]), .abort(abort_a[2]), .num_gates(ng_a[2]),
    .gate_bus(gbus2), .mult_state(ms_a[2]), .mult_gate(mg_a[2]), .mult_result(mr_a[2]),
    .state_out(so_a[2]), .gates_done(gd_a[2]), .busy(busy_a[2]), .done(done_a[2])
  );

  function automatic int sm2i(input logic [7:0] v);
    return v[7] ? -int'(v[6:0]) : int'(v[6:0]);
  endfunction

  function automatic logic [7:0] i2sm(input int v);
    int m;
    m = (v < 0) ? -v : v;
    if (m > 127) m = 127;
    return {(v < 0), m[6:0]};
  endfunction

  function automatic vec_t mat_mul(input mat_t g, input vec_t s);
    vec_t r;
    int   re, im, ar, ai, br, bi;
    for (int unsigned row = 0; row < DIM; row++) begin
      re = 0;
      im = 0;
      for (int unsigned c = 0; c < DIM; c++) begin
        ar = sm2i(g[row][c][15:8]);
        ai = sm2i(g[row][c][7:0]);
        br = sm2i(s[c][15:8]);
        bi = sm2i(s[c][7:0]);
        re += (ar * br - ai * bi) / 64;
        im += (ar * bi + ai * br) / 64;
      end
      r[row] = {i2sm(re), i2sm(im)};
    end
    return r;
  endfunction

  function automatic vec_t pat(input int i);
    vec_t v;
    for (int unsigned k = 0; k < DIM; k++) v[k] = {8'(i * 16 + int'(k) + 1), 8'(i + 3)};
    return v;
  endfunction

  always_comb begin
    mr_a[0] = mat_mul(mg_a[0], ms_a[0]);
    mr_a[1] = mat_mul(mg_a[1], ms_a[1]);
    mr_a[2] = pat_v;
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One run on instance d; cycle 0 is the start cycle, done_cyc counts start..done inclusive.
  task automatic run_seq(input int d, input logic [7:0] ng, input int stall, input int abort_cyc);
    int hs, stall_left;
    hs = 0;
    stall_left = stall;
    done_cyc = 0;
    ready_seen = 0;
    stall_ready_ok = 1;
    busy_after_abort = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i > 0 && done_a[d] === 1'b1) begin
        done_cyc = i + 1;
        break;
      end
      if (gr_a[d] === 1'b1) ready_seen = 1;
      if (i == abort_cyc + 1) busy_after_abort = busy_a[d];
      start_a[d] = (i == 0);
      ng_a[d]    = ng;
      abort_a[d] = (i == abort_cyc);
      gin_a[d]   = xi;
      gv_a[d]    = 1'b1;
      if (hs == 1 && stall_left > 0) begin
        if (stall_left < stall && gr_a[d] !== 1'b1) stall_ready_ok = 0;
        if (gr_a[d] === 1'b1) begin
          gv_a[d] = 1'b0;
          stall_left--;
        end
      end
      if (gv_a[d] && gr_a[d] === 1'b1) hs++;
    end
    start_a[d] = 1'b0;
    abort_a[d] = 1'b0;
  endtask

  initial begin
    xi = '0;
    xi[0][2] = 16'h4000;
    xi[1][3] = 16'h4000;
    xi[2][0] = 16'h4000;
    xi[3][1] = 16'h4000;
    e0 = '0;
    e0[0] = 16'h4000;
    e2 = '0;
    e2[2] = 16'h4000;
    pat_v = '0;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start_a[k] = 1'b0;
      abort_a[k] = 1'b0;
      gv_a[k]    = 1'b0;
      ng_a[k]    = '0;
      gin_a[k]   = xi;
    end

    // Reset values on every instance
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst%0d_busy", d), 256'(busy_a[d]), 256'(1'b0));
      chk($sformatf("rst%0d_ready", d), 256'(gr_a[d]), 256'(1'b0));
      chk($sformatf("rst%0d_done", d), 256'(done_a[d]), 256'(1'b0));
      chk($sformatf("rst%0d_gates_done", d), 256'(gd_a[d]), 256'(8'd0));
      chk($sformatf("rst%0d_state_out", d), 256'(so_a[d]), 256'(0));
      chk($sformatf("rst%0d_mult_state", d), 256'(ms_a[d]), 256'(0));
      chk($sformatf("rst%0d_mult_gate", d), 256'(mg_a[d]), 256'(0));
    end

    // Idle with no start: busy must stay low for 20 cycles
    reset = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy_a[0] !== 1'b0) bad = 1;
    end
    chk("idle_busy", 256'(bad), 256'(0));

    // Single X(x)I gate at LAT=1: |00> -> |10>, done 6 cycles inclusive
    run_seq(0, 8'd1, 0, -1);
    chk("one_done_cyc", 256'(done_cyc), 256'(6));
    chk("one_state_out", 256'(so_a[0]), 256'(e2));
    chk("one_mult_state", 256'(ms_a[0]), 256'(e2));
    chk("one_gates_done", 256'(gd_a[0]), 256'(8'd1));
    chk("one_ready_seen", 256'(ready_seen), 256'(1));

    // Two X(x)I gates at LAT=2 with a 3-cycle source stall: 2+4+3+4+1
    run_seq(1, 8'd2, 3, -1);
    chk("two_done_cyc", 256'(done_cyc), 256'(14));
    chk("two_state_out", 256'(so_a[1]), 256'(e0));
    chk("two_gates_done", 256'(gd_a[1]), 256'(8'd2));
    chk("two_ready_in_stall", 256'(stall_ready_ok), 256'(1));

    // Abort in cycle 6 = APPLY of gate 2 of 3
    run_seq(0, 8'd3, 0, 6);
    chk("abort_no_done", 256'(done_cyc), 256'(0));
    chk("abort_busy_next", 256'(busy_after_abort), 256'(1'b0));
    chk("abort_gates_done", 256'(gd_a[0]), 256'(8'd1));
    chk("abort_state_out", 256'(so_a[0]), 256'(e2));
    chk("abort_mult_gate", 256'(mg_a[0]), 256'(xi));

    // start and abort together in IDLE: stays idle, nothing cleared
    @(negedge clk);
    start_a[0] = 1'b1;
    abort_a[0] = 1'b1;
    ng_a[0]    = 8'd1;
    @(negedge clk);
    start_a[0] = 1'b0;
    abort_a[0] = 1'b0;
    chk("startabort_busy", 256'(busy_a[0]), 256'(1'b0));
    chk("startabort_gates_done", 256'(gd_a[0]), 256'(8'd1));
    chk("startabort_state", 256'(so_a[0]), 256'(e2));

    // num_gates=0 re-initialises to |00> and finishes in 3 cycles
    run_seq(0, 8'd0, 0, -1);
    chk("zero_done_cyc", 256'(done_cyc), 256'(3));
    chk("zero_state_out", 256'(so_a[0]), 256'(e0));
    chk("zero_gates_done", 256'(gd_a[0]), 256'(8'd0));
    chk("zero_ready_seen", 256'(ready_seen), 256'(0));

    // Reset asserted mid-APPLY clears everything without a clock edge
    @(negedge clk);
    start_a[0] = 1'b1;
    ng_a[0]    = 8'd1;
    gv_a[0]    = 1'b1;
    gin_a[0]   = xi;
    @(negedge clk);
    start_a[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("preRst_busy", 256'(busy_a[0]), 256'(1'b1));
    chk("preRst_ready", 256'(gr_a[0]), 256'(1'b0));
    chk("preRst_mult_gate", 256'(mg_a[0]), 256'(xi));
    #1 reset = 1'b0;
    #1;
    chk("midRst_busy", 256'(busy_a[0]), 256'(1'b0));
    chk("midRst_ready", 256'(gr_a[0]), 256'(1'b0));
    chk("midRst_done", 256'(done_a[0]), 256'(1'b0));
    chk("midRst_gates_done", 256'(gd_a[0]), 256'(8'd0));
    chk("midRst_state_out", 256'(so_a[0]), 256'(0));
    chk("midRst_mult_state", 256'(ms_a[0]), 256'(0));
    chk("midRst_mult_gate", 256'(mg_a[0]), 256'(0));
    @(negedge clk);
    reset    = 1'b1;
    gv_a[0]  = 1'b0;

    // LAT=4: mult_result changes every cycle, only the WRITE-cycle (7) value lands;
    // a second start during APPLY (with num_gates=5) is ignored
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done_a[2] !== (i == 8)) bad = 1;
      if (gr_a[2] !== (i == 2)) bad = 1;
      if (i == 5) begin
        chk("lat4_apply_busy", 256'(busy_a[2]), 256'(1'b1));
        chk("lat4_apply_state", 256'(ms_a[2]), 256'(e0));
        chk("lat4_apply_gate", 256'(mg_a[2]), 256'(xi));
      end
      if (i == 8) chk("lat4_done_state", 256'(so_a[2]), 256'(pat(7)));
      start_a[2] = (i == 0) || (i == 4);
      ng_a[2]    = (i == 0) ? 8'd1 : 8'd5;
      gv_a[2]    = (i >= 2);
      gin_a[2]   = (i == 2) ? xi : ~xi;
      pat_v      = pat(i);
    end
    start_a[2] = 1'b0;
    gv_a[2]    = 1'b0;
    chk("lat4_timing", 256'(bad), 256'(0));
    chk("lat4_state_out", 256'(so_a[2]), 256'(pat(7)));
    chk("lat4_gates_done", 256'(gd_a[2]), 256'(8'd1));
    chk("lat4_busy_after", 256'(busy_a[2]), 256'(1'b0));
    chk("lat4_gate_held", 256'(mg_a[2]), 256'(xi));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gate_seq_ctrl.md
# gate_seq_ctrl

Sequencing controller for the complex gate-by-state matrix-vector multiplier (`gateStateMult`). It owns the quantum state register of 2^N complex elements and initialises it to |0…0⟩ on a start pulse. It then accepts a stream of 2^N × 2^N gate matrices over a valid/ready handshake and applies each one in turn by driving the multiplier and writing its result back. It reports completion after a programmed number of gates and sits between the gate source (ROM or host FIFO) and the multiplier datapath.

## Interface
- N, default 2: qubit count; state has 2^N elements, gate is 2^N × 2^N.
- LAT, default 1: cycles allowed for the multiplier result to settle after its inputs change; legal range 1–15.
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a run when idle.
- abort  input  1  one-cycle pulse; terminates any run.
- num_gates  input  8  gates to apply this run; sampled on the start cycle.
- gate_valid  input  1  gate_in holds a valid matrix.
- gate_ready  output  1  controller accepts a gate this cycle.
- gate_in  input  complexNum[2^N][2^N]  incoming gate matrix.
- mult_state  output  complexNum[2^N]  state vector driven to the multiplier (the state register).
- mult_gate  output  complexNum[2^N][2^N]  captured gate driven to the multiplier.
- mult_result  input  complexNum[2^N]  multiplier output state.
- state_out  output  complexNum[2^N]  current state register (same as mult_state).
- gates_done  output  8  gates applied in the current/last run.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at run completion.

## Operation
- Number format: complexNum with 8-bit sign-magnitude components and 6 fractional bits. 1.0 = 8'h40; 0 = 8'h00.
- The controller performs no arithmetic on state data; it only moves words between registers.
- FSM states: IDLE, INIT, LOAD, APPLY, WRITE, DONE.
- IDLE
  - busy=0, gate_ready=0.
  - start → INIT; num_gates is latched and gates_done cleared to 0.
- INIT (1 cycle)
  - State register ← element 0 = {8'h40, 8'h00}, all others {0,0}.
  - If the latched num_gates==0 → DONE, else → LOAD.
- LOAD
  - gate_ready=1.
  - On gate_valid&gate_ready, the gate register captures gate_in, the latency counter loads LAT−1, and the FSM → APPLY.
  - With gate_valid low, the FSM stays in LOAD indefinitely.
- APPLY
  - gate_ready=0. The counter decrements each cycle; at 0 → WRITE.
  - The state and gate registers are held stable throughout.
- WRITE (1 cycle)
  - State register ← mult_result; gates_done increments.
  - If the new gates_done equals the latched num_gates → DONE, else → LOAD.
- DONE (1 cycle)
  - done=1, then → IDLE.
  - state_out and gates_done hold until the next start.
- Signal behaviour across states:
  - start is ignored while busy.
  - gate_valid is ignored outside LOAD.
  - gate_in changes outside the handshake cycle have no effect.
- abort: from any non-IDLE state → IDLE on the next edge.
  - The state register keeps its last written value; the gate register is untouched; gates_done holds.
  - done is not pulsed.
  - abort has priority over every other transition in the same cycle.
  - abort and start together in IDLE: abort wins, the FSM stays IDLE.
- gates_done never exceeds the latched num_gates; no wrap is possible since num_gates ≤ 255.

## Timing
- Reset values:
  - FSM in IDLE; busy=0, gate_ready=0, done=0, gates_done=0.
  - State register and gate register all-zero; mult_state, state_out and mult_gate = 0.
- Reset is asynchronous on assertion and takes effect mid-operation.
- Start to first gate_ready: start accepted at edge k, INIT during cycle k+1, gate_ready high in cycle k+2.
- Per-gate cost with gate_valid held high: 1 handshake cycle + LAT APPLY cycles + 1 WRITE cycle = LAT+2 cycles.
- Run latency: start pulse to done pulse = 2 + num_gates·(LAT+2) + 1 cycles with no source stalls; with num_gates=0 it is 3 cycles.
- The multiplier is treated as combinational, with mult_result sampled only in WRITE.

## Test plan
- Reset/idle: assert reset mid-APPLY → all outputs at reset values immediately. Release reset with no start → busy stays 0 for 20 cycles.
- Single gate, N=2, LAT=1: start with num_gates=1 and gate = X⊗I (nonzero entries 8'h40 at (0,2),(1,3),(2,0),(3,1)); bench multiplier model.
  - Required: state_out[2]={40,00}, others 0; gates_done=1; done pulse 6 cycles after start.
- Two gates, X⊗I then X⊗I, gate_valid stalled 3 cycles before the second gate:
  - Required: state returns to element 0 = {40,00}; gate_ready stays high during the stall; done after 2+4+3+4+1 = 14 cycles.
- num_gates=0 → done exactly 3 cycles after start, state = |00⟩, gate_ready never asserted.
- Abort during APPLY of gate 2 of 3: busy drops next cycle, no done, gates_done=1, state holds the gate-1 result. A subsequent start re-initialises to |00⟩.
- LAT=4: gate presented with a changing mult_result during APPLY; only the WRITE-cycle value is captured. start pulses while busy are ignored.
